// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared bitwise logic unit,
// with a single registered result stage and per-requester completion counters.
module logic_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t       state;
    logic             ptr;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             take;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a ^ b);
            3'd4:    r = ~(a & b);
            3'd5:    r = ~a;
            3'd6:    r = ~b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Readies are held low during reset so no handshake completes in a cycle whose effect is discarded.
    always_comb begin
        can_accept = !rst && ((state == EMPTY) || out_ready);
        grant0     = req0_valid && (!req1_valid || !ptr);
        grant1     = req1_valid && (!req0_valid ||  ptr);
        req0_ready = can_accept && grant0;
        req1_ready = can_accept && grant1;
        accept     = req0_ready || req1_ready;
        take       = (state == FULL) && out_ready;
        sel_op     = grant1 ? req1_op : req0_op;
        sel_a      = grant1 ? req1_a  : req0_a;
        sel_b      = grant1 ? req1_b  : req0_b;
        result     = apply_op(sel_op, sel_a, sel_b);
    end

    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= 1'b0;
            out_data <= '0;
            out_id   <= 1'b0;
            out_err  <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else begin
            if (take) begin
                if (out_id) cnt1 <= cnt1 + CNT_W'(1);
                else        cnt0 <= cnt0 + CNT_W'(1);
            end
            if (accept) begin
                state    <= FULL;
                out_data <= result;
                out_id   <= req1_ready;
                out_err  <= (sel_op == 3'd7);
                ptr      <= ~req1_ready;
            end else if (take) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: a vector table for the main traffic
// patterns, plus hand-written sequences for mid-traffic reset and counter wrap.
module tb_logic_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       out_id, out_err;
    logic [7:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [2:0] op0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic       v1;
        logic [2:0] op1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       ordy;
        logic       e_r0;
        logic       e_r1;
        logic       e_ov;
        logic [7:0] e_data;
        logic       e_id;
        logic       e_err;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    vec_t vecs[28];

    logic_unit_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_err    (out_err),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst        = v.rst;
        req0_valid = v.v0;
        req0_op    = v.op0;
        req0_a     = v.a0;
        req0_b     = v.b0;
        req1_valid = v.v1;
        req1_op    = v.op1;
        req1_a     = v.a1;
        req1_b     = v.b1;
        out_ready  = v.ordy;
    endtask

    // Inputs change on the falling edge; readies are checked before the
    // rising edge and registered outputs 1ns after it.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        apply_stimulus(v);
        #1;
        check_output({tag, " req0_ready"}, 32'(req0_ready), 32'(v.e_r0));
        check_output({tag, " req1_ready"}, 32'(req1_ready), 32'(v.e_r1));
        @(posedge clk);
        #1;
        check_output({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
        check_output({tag, " out_data"},  32'(out_data),  32'(v.e_data));
        check_output({tag, " out_id"},    32'(out_id),    32'(v.e_id));
        check_output({tag, " out_err"},   32'(out_err),   32'(v.e_err));
        check_output({tag, " cnt0"},      32'(cnt0),      32'(v.e_c0));
        check_output({tag, " cnt1"},      32'(cnt1),      32'(v.e_c1));
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;

        // rst v0 op0 a0 b0 | v1 op1 a1 b1 | ordy | r0 r1 ov data id err c0 c1
        vecs[0]  = '{1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0, 0,0,0,8'h00,0,0,8'd0,8'd0};
        // req0 alone, every legal op
        vecs[1]  = '{0,1,0,8'hC5,8'h3A, 0,0,8'h00,8'h00, 1, 1,0,1,8'h00,0,0,8'd0,8'd0};
        vecs[2]  = '{0,1,1,8'hC5,8'h3A, 0,0,8'h00,8'h00, 1, 1,0,1,8'hFF,0,0,8'd1,8'd0};
        vecs[3]  = '{0,1,2,8'hC5,8'h3A, 0,0,8'h00,8'h00, 1, 1,0,1,8'hFF,0,0,8'd2,8'd0};
        vecs[4]  = '{0,1,3,8'hC5,8'h3A, 0,0,8'h00,8'h00, 1, 1,0,1,8'h00,0,0,8'd3,8'd0};
        vecs[5]  = '{0,1,4,8'hC5,8'h3A, 0,0,8'h00,8'h00, 1, 1,0,1,8'hFF,0,0,8'd4,8'd0};
        vecs[6]  = '{0,1,5,8'hC5,8'h3A, 0,0,8'h00,8'h00, 1, 1,0,1,8'h3A,0,0,8'd5,8'd0};
        vecs[7]  = '{0,1,6,8'hC5,8'h3A, 0,0,8'h00,8'h00, 1, 1,0,1,8'hC5,0,0,8'd6,8'd0};
        vecs[8]  = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'hC5,0,0,8'd7,8'd0};
        // contention: pointer is 1 after req0's last grant, so req1 goes first
        vecs[9]  = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 1, 0,1,1,8'hF0,1,0,8'd7,8'd0};
        vecs[10] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 1, 1,0,1,8'hFF,0,0,8'd7,8'd1};
        vecs[11] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 1, 0,1,1,8'hF0,1,0,8'd8,8'd1};
        vecs[12] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 1, 1,0,1,8'hFF,0,0,8'd8,8'd2};
        vecs[13] = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'hFF,0,0,8'd9,8'd2};
        // backpressure: one accept, then stall, then the other requester on release
        vecs[14] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 0, 0,1,1,8'hF0,1,0,8'd9,8'd2};
        vecs[15] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 0, 0,0,1,8'hF0,1,0,8'd9,8'd2};
        vecs[16] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 0, 0,0,1,8'hF0,1,0,8'd9,8'd2};
        vecs[17] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 0, 0,0,1,8'hF0,1,0,8'd9,8'd2};
        vecs[18] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 0, 0,0,1,8'hF0,1,0,8'd9,8'd2};
        vecs[19] = '{0,1,2,8'hC5,8'h3A, 1,5,8'h0F,8'h00, 1, 1,0,1,8'hFF,0,0,8'd9,8'd3};
        vecs[20] = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'hFF,0,0,8'd10,8'd3};
        // illegal opcode from req1
        vecs[21] = '{0,0,0,8'h00,8'h00, 1,7,8'hFF,8'hFF, 0, 0,1,1,8'h00,1,1,8'd10,8'd3};
        vecs[22] = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'h00,1,1,8'd10,8'd4};
        // req1 alone while pointer favours req0
        vecs[23] = '{0,0,0,8'h00,8'h00, 1,0,8'hF0,8'h3C, 1, 0,1,1,8'h30,1,0,8'd10,8'd4};
        vecs[24] = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'h30,1,0,8'd10,8'd5};
        // req1 waits behind a stalled result, then withdraws
        vecs[25] = '{0,1,1,8'h0F,8'hF0, 0,0,8'h00,8'h00, 0, 1,0,1,8'hFF,0,0,8'd10,8'd5};
        vecs[26] = '{0,0,0,8'h00,8'h00, 1,2,8'h12,8'h34, 0, 0,0,1,8'hFF,0,0,8'd10,8'd5};
        vecs[27] = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'hFF,0,0,8'd11,8'd5};

        for (int i = 0; i < 28; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while FULL with pointer at 1 and an acceptable request pending.
        v = '{0,1,2,8'hAA,8'h55, 0,0,8'h00,8'h00, 0, 1,0,1,8'hFF,0,0,8'd11,8'd5};
        run_vec(v, "rst_fill");
        v = '{1,1,0,8'hAA,8'h55, 1,0,8'hAA,8'h55, 1, 0,0,0,8'h00,0,0,8'd0,8'd0};
        run_vec(v, "rst_mid");
        v = '{0,1,1,8'hAA,8'h55, 1,5,8'h0F,8'h00, 0, 1,0,1,8'hFF,0,0,8'd0,8'd0};
        run_vec(v, "rst_after");

        // Counter wrap: cnt1 parked at 1, then 256 req0 results in total.
        v = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'hFF,0,0,8'd1,8'd0};
        run_vec(v, "wrap_take");
        v = '{0,0,0,8'h00,8'h00, 1,0,8'hF0,8'h3C, 1, 0,1,1,8'h30,1,0,8'd1,8'd0};
        run_vec(v, "wrap_r1");
        v = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'h30,1,0,8'd1,8'd1};
        run_vec(v, "wrap_r1_take");
        for (int k = 0; k < 255; k++) begin
            v = '{0,1,0,8'(k),8'hFF, 0,0,8'h00,8'h00, 1, 1,0,1,8'(k),0,0,8'(k + 1),8'd1};
            run_vec(v, $sformatf("wrap%0d", k));
        end
        v = '{0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1, 0,0,0,8'hFE,0,0,8'd0,8'd1};
        run_vec(v, "wrap_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/XNOR/NAND/NOT) between two requesters.
- Round-robin arbitration, valid/ready handshakes on both request ports and on the result port, one registered output stage.
- Per-requester completion counters for bench and debug visibility.
- Sits between two operand producers and a single result consumer.

Parameters:
WIDTH, 8, operand/result width in bits
CNT_W, 8, width of each completion counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  3  requester 0 opcode
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
out_valid  output  1  result register holds a result
out_ready  input  1  consumer takes result this cycle
out_data  output  WIDTH  result
out_id  output  1  requester that issued the result
out_err  output  1  opcode was illegal
cnt0  output  CNT_W  results delivered to requester 0
cnt1  output  CNT_W  results delivered to requester 1

Behaviour:
- Reset: clk and rst as named above; rst is synchronous, active-high. On rst: out_valid=0, out_data=0, out_id=0, out_err=0, cnt0=cnt1=0, priority pointer=0. rst overrides all other activity in the same cycle, including mid-transaction; a held result is discarded.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND: a op b, bitwise.
  - 5 NOT a, 6 NOT b.
  - 7 illegal: result 0, out_err=1.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Accept condition: can_accept = EMPTY or (FULL and out_ready).
- Grant is combinational, only when can_accept:
  - Only one req valid: grant it.
  - Both valid: grant the requester named by the priority pointer.
  - reqN_ready = can_accept and grant==N. At most one ready high per cycle. Ready never asserts for a requester whose valid is low.
- On an accepted operation (valid & ready), next edge:
  - out_data = f(op, a, b); out_id = N; out_err = (op==7); out_valid = 1.
  - Priority pointer = 1-N.
  - Latency is 1 cycle from accept to out_valid.
- Priority pointer changes only on a grant.
- On out_valid & out_ready with no new accept: out_valid=0 next edge; data, id and err hold their old values.
- Back-to-back: FULL with out_ready=1 and a request valid gives a simultaneous take and accept; out_valid stays 1 and new data is loaded. Throughput is 1 result per cycle.
- FULL with out_ready=0: no ready asserted; out_data, out_id and out_err stable until taken.
- Counters:
  - cntN increments when a result with out_id==N is taken (out_valid & out_ready).
  - Wraps modulo 2^CNT_W (255→0 at CNT_W=8).
  - Illegal-op results are counted too.
- Requester inputs are sampled only in the accept cycle. A requester may drop valid before being granted; no state is retained.

Test Plan:
- Reset mid-traffic: FULL holding data, assert rst one cycle → out_valid=0, cnt0=cnt1=0, pointer=0; next cycle both valid → grant req0.
- Single requester, all ops: req0 a=8'hC5, b=8'h3A, op 0..6, out_ready=1 → results 00, FF, FF, 00, FF, 3A, C5 on consecutive cycles; out_id=0; cnt0=7.
- Contention fairness: both valid continuously, out_ready=1 → grants alternate 0,1,0,1…; req1 ops are all NOT a with a=8'h0F → out_data F0 on odd results; cnt0=cnt1 after an even number of results.
- Backpressure: out_ready=0 with both valid for 5 cycles → exactly one accept, then both ready=0 and out_data stable; raise out_ready → the other requester is granted in the same cycle.
- Illegal opcode: req1 op=7, a=b=8'hFF → out_data=00, out_err=1, out_id=1, cnt1 increments on take.
- Counter wrap: 256 taken req0 results, CNT_W=8 → cnt0=0, cnt1 unchanged.
